// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, bit-period defaults
// and frame width, used by the receiver and the bit timer.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  localparam int UART_CLOCKS_PER_BIT_DEFAULT = 434;
  localparam int UART_CLOCKS_PER_BIT_SIM     = 6;
  localparam int UART_DATA_BITS              = 8;

endpackage

// File: rtl/uart_receive_deserializer_if.sv
// Consumer-side port bundle of the UART receiver: holding register plus
// its Full/Empty handshake and the sticky error flags.
interface uart_receive_deserializer_if;
  import uart_pkg::*;

  // Handshake: RX_data is valid whenever Empty=0. The consumer takes the byte
  // by pulsing Unload_data for one cycle, which sets Empty and clears both
  // flags on the next edge; RX_data itself holds its last value.
  logic                      Unload_data;
  logic [UART_DATA_BITS-1:0] RX_data;
  logic                      Empty;
  logic                      Overrun;
  logic                      Frame_error;

  modport master (
    input  Unload_data,
    output RX_data,
    output Empty,
    output Overrun,
    output Frame_error
  );

  modport slave (
    output Unload_data,
    input  RX_data,
    input  Empty,
    input  Overrun,
    input  Frame_error
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter with synchronous clear and a terminal-count flag at
// either the half-bit or the full-bit point; shared by receiver and transmitter.
module uart_bit_timer #(
  parameter int PERIOD = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic half_sel,
  output logic tc
);

  localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0] FULL_LAST = W'(PERIOD - 1);
  localparam logic [W-1:0] HALF_LAST = W'(PERIOD / 2 - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == (half_sel ? HALF_LAST : FULL_LAST));

endmodule

// File: rtl/uart_receive_deserializer.sv
// 8N1 UART receiver: synchronizes UART_RX_I, samples mid-bit, and delivers
// each good byte into a one-deep holding register with sticky error flags.
module uart_receive_deserializer
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = UART_CLOCKS_PER_BIT_DEFAULT
) (
  input  logic                               Clock_50,
  input  logic                               Resetn,
  input  logic                               Enable,
  input  logic                               UART_RX_I,
  uart_receive_deserializer_if.master        rx_if,
  output uart_rx_state_t                     state_dbg
);

  if (CLOCKS_PER_BIT < 4) begin : g_bad_period
    $error("CLOCKS_PER_BIT must be at least 4");
  end

  logic sync1_q, sync2_q, sync3_q;
  logic rx_s;
  logic rx_fall;

  uart_rx_state_t state_q, state_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic stop_done_q, stop_done_d;
  logic stop_bit_q, stop_bit_d;

  logic [UART_DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic empty_q, empty_d;
  logic overrun_q, overrun_d;
  logic frame_error_q, frame_error_d;

  logic timer_clr;
  logic half_sel;
  logic tc;

  assign rx_s    = sync2_q;
  assign rx_fall = sync3_q & ~sync2_q;

  uart_bit_timer #(
    .PERIOD (CLOCKS_PER_BIT)
  ) u_bit_timer (
    .clk      (Clock_50),
    .rst_n    (Resetn),
    .clr      (timer_clr),
    .half_sel (half_sel),
    .tc       (tc)
  );

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    stop_done_d = 1'b0;
    stop_bit_d  = stop_bit_q;
    timer_clr   = 1'b0;
    half_sel    = 1'b0;
    case (state_q)
      IDLE: begin
        timer_clr = 1'b1;
        if (rx_fall) begin
          state_d = START;
        end
      end
      START: begin
        half_sel = 1'b1;
        if (tc) begin
          // A line that is high again at mid-start was a glitch, not a frame.
          if (!rx_s) begin
            timer_clr = 1'b1;
            bit_idx_d = '0;
            state_d   = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tc) begin
          shift_d[bit_idx_q] = rx_s;
          timer_clr          = 1'b1;
          if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (tc) begin
          stop_done_d = 1'b1;
          stop_bit_d  = rx_s;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!Enable) begin
      state_d     = IDLE;
      timer_clr   = 1'b1;
      stop_done_d = 1'b0;
    end
  end

  // Unload is applied first so a byte landing in the same cycle sees the slot free.
  always_comb begin
    rx_data_d     = rx_data_q;
    empty_d       = empty_q;
    overrun_d     = overrun_q;
    frame_error_d = frame_error_q;
    if (rx_if.Unload_data) begin
      empty_d       = 1'b1;
      overrun_d     = 1'b0;
      frame_error_d = 1'b0;
    end
    if (stop_done_q) begin
      if (!stop_bit_q) begin
        frame_error_d = 1'b1;
      end else if (empty_q || rx_if.Unload_data) begin
        rx_data_d = shift_q;
        empty_d   = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      sync3_q       <= 1'b1;
      state_q       <= IDLE;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      stop_done_q   <= 1'b0;
      stop_bit_q    <= 1'b1;
      rx_data_q     <= '0;
      empty_q       <= 1'b1;
      overrun_q     <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      sync1_q       <= UART_RX_I;
      sync2_q       <= sync1_q;
      sync3_q       <= sync2_q;
      state_q       <= state_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      stop_done_q   <= stop_done_d;
      stop_bit_q    <= stop_bit_d;
      rx_data_q     <= rx_data_d;
      empty_q       <= empty_d;
      overrun_q     <= overrun_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign rx_if.RX_data     = rx_data_q;
  assign rx_if.Empty       = empty_q;
  assign rx_if.Overrun     = overrun_q;
  assign rx_if.Frame_error = frame_error_q;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_uart_receive_deserializer.sv
// Bench for uart_receive_deserializer at 6 clocks per bit: a vector table of
// whole frames plus hand-written sequences for timing and corner cases.
module tb_uart_receive_deserializer;
  import uart_pkg::*;

  localparam int CPB = UART_CLOCKS_PER_BIT_SIM;

  logic clk;
  logic rst_n;
  logic enable;
  logic rx_pin;
  uart_rx_state_t state_dbg;

  int n_pass;
  int n_total;

  uart_receive_deserializer_if rx_if ();

  uart_receive_deserializer #(
    .CLOCKS_PER_BIT (CPB)
  ) dut (
    .Clock_50  (clk),
    .Resetn    (rst_n),
    .Enable    (enable),
    .UART_RX_I (rx_pin),
    .rx_if     (rx_if.master),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       unload;
    logic [7:0] exp_data;
    logic       exp_empty;
    logic       exp_ovr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[7];

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] d, input logic e,
                            input logic o, input logic f);
    check($sformatf("%s RX_data", tag), rx_if.RX_data, d);
    check($sformatf("%s Empty", tag), 8'(rx_if.Empty), 8'(e));
    check($sformatf("%s Overrun", tag), 8'(rx_if.Overrun), 8'(o));
    check($sformatf("%s Frame_error", tag), 8'(rx_if.Frame_error), 8'(f));
  endtask

  task automatic check_state(input string tag, input uart_rx_state_t exp);
    check($sformatf("%s state", tag), 8'(state_dbg), 8'(exp));
  endtask

  // ---------------- drivers ----------------
  // Called at posedge+1; each frame bit is held for exactly CPB clocks.
  task automatic drive_frame(input logic [7:0] data, input logic stop, input int ncyc);
    logic [9:0] frame;
    frame = {stop, data, 1'b0};
    for (int i = 0; i < ncyc; i++) begin
      rx_pin = frame[i / CPB];
      @(posedge clk);
      #1;
    end
    rx_pin = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    drive_frame(data, stop, 10 * CPB);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_unload();
    rx_if.Unload_data = 1'b1;
    @(posedge clk);
    #1;
    rx_if.Unload_data = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_pass  = 0;
    n_total = 0;
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h22, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};

    rst_n             = 1'b0;
    enable            = 1'b1;
    rx_pin            = 1'b1;
    rx_if.Unload_data = 1'b0;
    idle(3);
    check_outs("reset", 8'h00, 1'b1, 1'b0, 1'b0);
    check_state("reset", IDLE);
    rst_n = 1'b1;
    idle(3);

    // Exact output timing: stop sample at edge 60, outputs on edge 61.
    send_frame(8'h96, 1'b1);
    check("timing Empty before edge 61", 8'(rx_if.Empty), 8'd1);
    idle(1);
    check_outs("timing 96", 8'h96, 1'b0, 1'b0, 1'b0);
    pulse_unload();
    check_outs("timing 96 unload", 8'h96, 1'b1, 1'b0, 1'b0);
    idle(2);

    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].data, vecs[i].stop);
      idle(1);
      check_outs($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_empty,
                 vecs[i].exp_ovr, vecs[i].exp_ferr);
      if (vecs[i].unload) begin
        pulse_unload();
        check_outs($sformatf("vec%0d unload", i), vecs[i].exp_data, 1'b1, 1'b0, 1'b0);
      end
      idle(2);
    end

    // Two-cycle low glitch: detected at edge 3, rejected at the edge-6 start sample.
    rx_pin = 1'b0;
    idle(1);
    idle(1);
    rx_pin = 1'b1;
    idle(1);
    check_state("glitch detect", START);
    idle(2);
    check_state("glitch mid", START);
    idle(1);
    check_state("glitch reject", IDLE);
    idle(3);
    check_outs("glitch", 8'h00, 1'b1, 1'b0, 1'b0);

    // Enable dropped while bit 4 of 8'h5A is being received.
    drive_frame(8'h5A, 1'b1, 33);
    check_state("pre-disable", DATA);
    enable = 1'b0;
    idle(1);
    check_state("disabled", IDLE);
    idle(1);
    enable = 1'b1;
    idle(3);
    check_outs("after disable", 8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(8'h0F, 1'b1);
    idle(1);
    check_outs("reenabled 0F", 8'h0F, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Unload in the same cycle as a good byte arriving on a full register.
    send_frame(8'h77, 1'b1);
    pulse_unload();
    check_outs("unload+good", 8'h77, 1'b0, 1'b0, 1'b0);
    idle(2);

    send_frame(8'h88, 1'b1);
    idle(1);
    check_outs("overrun 88", 8'h77, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Unload coinciding with a framing error: error set wins, overrun cleared.
    send_frame(8'h99, 1'b0);
    pulse_unload();
    check_outs("unload+ferr", 8'h77, 1'b1, 1'b0, 1'b1);
    idle(2);

    // Asynchronous reset mid-frame.
    drive_frame(8'hA5, 1'b1, 30);
    rst_n = 1'b0;
    #2;
    check_outs("async reset", 8'h00, 1'b1, 1'b0, 1'b0);
    check_state("async reset", IDLE);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);
    check_outs("after reset", 8'h00, 1'b1, 1'b0, 1'b0);
    check_state("after reset", IDLE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
